// File: rtl/ov7670_config_sequencer_if.sv
// ov7670_config_sequencer_if: config ROM read port and SCCB write-request handshake
interface ov7670_config_sequencer_if #(parameter int ADDR_W = 8);
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        cmd_reg;
  logic [7:0]        cmd_val;
  modport master(output rom_addr, cmd_valid, cmd_reg, cmd_val, input rom_data, cmd_ready);
  modport slave(input rom_addr, cmd_valid, cmd_reg, cmd_val, output rom_data, cmd_ready);
endinterface

// File: rtl/ov7670_config_sequencer.sv
// ov7670_config_sequencer: walks a register-table ROM and issues one SCCB write per entry
module ov7670_config_sequencer #(
  parameter int          ADDR_W       = 8,
  parameter int          DELAY_CYCLES = 240000,
  parameter logic [15:0] END_MARK     = 16'hFFFF,
  parameter logic [15:0] DELAY_MARK   = 16'hFFF0,
  parameter int          CNT_W        = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  ov7670_config_sequencer_if.master    bus,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun,
  output logic [CNT_W-1:0]             writes_done
);
  localparam int DW = DELAY_CYCLES > 1 ? $clog2(DELAY_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, SEND, WAIT, FIN} state_t;
  state_t            state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic              valid, valid_n, busy_n, done_n, ovr_n, step;
  logic [7:0]        creg, creg_n, cval, cval_n;
  logic [CNT_W-1:0]  wd_n;
  logic [DW-1:0]     cnt, cnt_n;
  assign bus.rom_addr  = addr;
  assign bus.cmd_valid = valid;
  assign bus.cmd_reg   = creg;
  assign bus.cmd_val   = cval;
  // state and all registered outputs; reset clears everything at once, even mid-handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr        <= '0;
      valid       <= 1'b0;
      creg        <= '0;
      cval        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
      writes_done <= '0;
      cnt         <= '0;
    end else begin
      state       <= state_n;
      addr        <= addr_n;
      valid       <= valid_n;
      creg        <= creg_n;
      cval        <= cval_n;
      busy        <= busy_n;
      done        <= done_n;
      overrun     <= ovr_n;
      writes_done <= wd_n;
      cnt         <= cnt_n;
    end
  end
  // next state; step marks an entry finished (write accepted or delay expired) so the address can advance
  always_comb begin
    state_n = state;
    addr_n  = addr;
    valid_n = valid;
    creg_n  = creg;
    cval_n  = cval;
    busy_n  = busy;
    done_n  = done;
    ovr_n   = overrun;
    wd_n    = writes_done;
    cnt_n   = cnt;
    step    = 1'b0;
    case (state)
      IDLE, FIN: if (start) begin
        state_n = FETCH;
        addr_n  = '0;
        busy_n  = 1'b1;
        done_n  = 1'b0;
        ovr_n   = 1'b0;
        wd_n    = '0;
      end
      FETCH: state_n = DECODE;
      DECODE: if (bus.rom_data == END_MARK) begin
        state_n = FIN;
        busy_n  = 1'b0;
        done_n  = 1'b1;
      end else if (bus.rom_data == DELAY_MARK) begin
        cnt_n   = DW'(DELAY_CYCLES - 1);
        state_n = WAIT;
      end else begin
        creg_n  = bus.rom_data[15:8];
        cval_n  = bus.rom_data[7:0];
        valid_n = 1'b1;
        state_n = SEND;
      end
      SEND: if (bus.cmd_ready) begin
        valid_n = 1'b0;
        wd_n    = &writes_done ? writes_done : writes_done + 1'b1;
        step    = 1'b1;
      end
      WAIT: begin
        step  = cnt == '0;
        cnt_n = step ? cnt : cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (step) begin
      state_n = &addr ? FIN : FETCH;
      addr_n  = &addr ? addr : addr + 1'b1;
      ovr_n   = &addr | ovr_n;
      busy_n  = ~&addr;
      done_n  = &addr;
    end
  end
endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// tb_ov7670_config_sequencer: table, hand-sequence and randomized checks of the config sequencer
module tb_ov7670_config_sequencer;
  localparam int AW = 2, DLY = 5, CW = 2;
  logic clk = 0, rst = 1, start = 0;
  logic busy, done, overrun;
  logic [CW-1:0] writes_done;
  ov7670_config_sequencer_if #(.ADDR_W(AW)) bus();
  ov7670_config_sequencer #(.ADDR_W(AW), .DELAY_CYCLES(DLY), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .busy(busy), .done(done), .overrun(overrun), .writes_done(writes_done));
  always #5 clk = ~clk;
  logic [15:0] rom [4];
  int tests = 0, fails = 0;
  // registered ROM: data for an address appears one edge after the address
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];
  int ready_mode = 0;
  logic ready_force = 0;
  // ready driver: 0 always ready, 1 random, 2 forced level
  always @(negedge clk)
    bus.cmd_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'($urandom_range(0, 1)) : ready_force;
  logic [15:0] got[$];
  logic [15:0] held;
  logic hold = 0;
  int stab_err = 0;
  // monitor: log accepted writes and flag any change of a pending request
  always @(posedge clk) begin
    if (rst) hold = 0;
    else begin
      if (hold && (!bus.cmd_valid || {bus.cmd_reg, bus.cmd_val} !== held)) stab_err++;
      if (bus.cmd_valid && bus.cmd_ready) got.push_back({bus.cmd_reg, bus.cmd_val});
      hold = bus.cmd_valid && !bus.cmd_ready;
      held = {bus.cmd_reg, bus.cmd_val};
    end
  end
  logic [15:0] exp_q[$];
  logic exp_ovr;
  int exp_addr;
  // reference: every non-marker entry up to END_MARK is written; running off the table is an overrun
  function automatic void model();
    exp_q.delete();
    exp_ovr = 1;
    exp_addr = 3;
    for (int i = 0; i < 4; i++) begin
      if (rom[i] == 16'hFFFF) begin
        exp_ovr = 0;
        exp_addr = i;
        return;
      end
      if (rom[i] != 16'hFFF0) exp_q.push_back(rom[i]);
    end
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  task automatic pulse_start();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " done_timeout"}, 32'(n < 400), 1);
  endtask
  task automatic wait_valid(input string nm);
    int n = 0;
    while (!bus.cmd_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " valid_timeout"}, 32'(n < 20), 1);
  endtask
  task automatic chk_stream(input string nm, input int base);
    bit ok = got.size() - base == exp_q.size();
    for (int i = 0; ok && i < exp_q.size(); i++) ok = got[base + i] == exp_q[i];
    chk({nm, " stream"}, 32'(ok), 1);
  endtask
  task automatic run_check(input string nm, input int n, input int wd, input int ovr, input int addr);
    int base = got.size();
    int s0 = stab_err;
    model();
    pulse_start();
    wait_done(nm);
    chk({nm, " nwrites"}, got.size() - base, n);
    chk_stream(nm, base);
    chk({nm, " busy"}, 32'(busy), 0);
    chk({nm, " overrun"}, 32'(overrun), ovr);
    chk({nm, " writes_done"}, 32'(writes_done), wd);
    chk({nm, " rom_addr"}, 32'(bus.rom_addr), addr);
    chk({nm, " cmd_valid"}, 32'(bus.cmd_valid), 0);
    chk({nm, " stable"}, stab_err - s0, 0);
  endtask
  // counts negedges after the start edge; first/second write request and done arrival
  task automatic timing(input int extra, output int first, output int second, output int fin, output int nv);
    bit pv = 0;
    first = -1; second = -1; fin = -1; nv = 0;
    @(negedge clk);
    start = 1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = k == extra;
      if (bus.cmd_valid && !pv) begin
        nv++;
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
      pv = bus.cmd_valid;
      if (done && fin < 0) fin = k;
    end
    start = 0;
  endtask
  typedef struct {
    logic [0:3][15:0] t;
    int n, wd, ovr, addr;
    string name;
  } vec_t;
  vec_t vecs[7];
  int f, s, d, nv, base;
  logic [15:0] v;
  initial begin
    vecs[0] = '{{16'h1280, 16'hFFF0, 16'h1210, 16'hFFFF}, 2, 2, 0, 3, "v_delay"};
    vecs[1] = '{{16'hFFFF, 16'h1234, 16'h5678, 16'h9ABC}, 0, 0, 0, 0, "v_end0"};
    vecs[2] = '{{16'h0102, 16'h0304, 16'h0506, 16'h0708}, 4, 3, 1, 3, "v_overrun_sat"};
    vecs[3] = '{{16'hFFF0, 16'hFFF0, 16'hFFF0, 16'hFFF0}, 0, 0, 1, 3, "v_all_delay"};
    vecs[4] = '{{16'hAB12, 16'hFFFF, 16'h0000, 16'h0000}, 1, 1, 0, 1, "v_end1"};
    vecs[5] = '{{16'hFFF0, 16'h00FF, 16'hFFFF, 16'h1111}, 1, 1, 0, 2, "v_end2"};
    vecs[6] = '{{16'h3A04, 16'hFFF0, 16'hFFF0, 16'h0000}, 2, 2, 1, 3, "v_tail_delay"};
    for (int i = 0; i < 4; i++) rom[i] = vecs[0].t[i];
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset overrun", 32'(overrun), 0);
    chk("reset writes_done", 32'(writes_done), 0);
    chk("reset cmd_valid", 32'(bus.cmd_valid), 0);
    chk("reset rom_addr", 32'(bus.rom_addr), 0);
    rst = 0;
    foreach (vecs[j]) begin
      for (int i = 0; i < 4; i++) rom[i] = vecs[j].t[i];
      run_check(vecs[j].name, vecs[j].n, vecs[j].wd, vecs[j].ovr, vecs[j].addr);
    end
    // first request 3 cycles after start; delay entry costs its fetch/decode plus DLY cycles
    for (int i = 0; i < 4; i++) rom[i] = vecs[0].t[i];
    timing(0, f, s, d, nv);
    chk("t1 first_valid", f, 3);
    chk("t1 second_valid", s, 3 + 1 + 2 + DLY + 2);
    chk("t1 done_at", d, 3 + 1 + 2 + DLY + 2 + 1 + 2);
    // start while busy is ignored: same timing as above
    timing(7, f, s, d, nv);
    chk("t5 busy_start first", f, 3);
    chk("t5 busy_start done_at", d, 3 + 1 + 2 + DLY + 2 + 1 + 2);
    chk("t5 busy_start nvalid", nv, 2);
    // restart from FIN clears status and replays the identical stream
    model();
    base = got.size();
    pulse_start();
    chk("t5 restart done", 32'(done), 0);
    chk("t5 restart writes_done", 32'(writes_done), 0);
    chk("t5 restart busy", 32'(busy), 1);
    wait_done("t5");
    chk_stream("t5 restart", base);
    for (int i = 0; i < 4; i++) rom[i] = vecs[1].t[i];
    timing(0, f, s, d, nv);
    chk("t6 done_at", d, 3);
    chk("t6 nvalid", nv, 0);
    // backpressure: request held 20 cycles without change, counted once
    for (int i = 0; i < 4; i++) rom[i] = vecs[0].t[i];
    ready_mode = 2;
    ready_force = 0;
    base = got.size();
    pulse_start();
    wait_valid("t2");
    held = 0;
    nv = 0;
    v = {bus.cmd_reg, bus.cmd_val};
    repeat (20) begin
      @(negedge clk);
      if (!bus.cmd_valid || {bus.cmd_reg, bus.cmd_val} !== v) nv++;
    end
    chk("t2 held_stable", nv, 0);
    chk("t2 held_value", v, 16'h1280);
    chk("t2 none_accepted", got.size() - base, 0);
    ready_mode = 0;
    wait_done("t2");
    chk("t2 nwrites", got.size() - base, 2);
    chk("t2 writes_done", 32'(writes_done), 2);
    // async reset in SEND then in WAIT drops outputs immediately
    ready_mode = 2;
    pulse_start();
    wait_valid("t4 send");
    #2 rst = 1;
    #1;
    chk("t4 send cmd_valid", 32'(bus.cmd_valid), 0);
    chk("t4 send busy", 32'(busy), 0);
    chk("t4 send cmd_reg", 32'(bus.cmd_reg), 0);
    chk("t4 send cmd_val", 32'(bus.cmd_val), 0);
    @(negedge clk);
    rst = 0;
    ready_mode = 0;
    pulse_start();
    wait_valid("t4 wait");
    repeat (4) @(negedge clk);
    chk("t4 pre writes_done", 32'(writes_done), 1);
    #2 rst = 1;
    #1;
    chk("t4 wait busy", 32'(busy), 0);
    chk("t4 wait writes_done", 32'(writes_done), 0);
    chk("t4 wait rom_addr", 32'(bus.rom_addr), 0);
    @(negedge clk);
    rst = 0;
    run_check("t4 replay", 2, 2, 0, 3);
    // randomized tables and backpressure against the reference
    ready_mode = 1;
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 4; i++) begin
        v = 16'($urandom);
        if (v == 16'hFFFF || v == 16'hFFF0) v = 16'h1234;
        case ($urandom_range(0, 5))
          0: rom[i] = 16'hFFFF;
          1: rom[i] = 16'hFFF0;
          default: rom[i] = v;
        endcase
      end
      model();
      run_check("rand", exp_q.size(), exp_q.size() > 3 ? 3 : exp_q.size(), exp_ovr, exp_addr);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
